div: RTL

- Multi-cycle 32-bit signed/unsigned integer divider (restoring, 1 quotient bit/cycle) used by the EX stage for DIV/DIVU.
- EX drives start/operands and holds its stall request until ready_o.
- The stall controller then freezes stages 0..3 through the stall[5:0] vector consumed by the pipeline registers; this block ends that stall by raising ready_o.
- Result goes to HI (remainder) / LO (quotient) via EX/MEM.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_step.sv | 22 ++
 rtl/div.sv | 116 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle divider.
package div_pkg;

  localparam int WIDTH   = 32;
  localparam int REG_BUS = WIDTH;
  localparam int CNT_W   = 6;

  typedef logic [REG_BUS-1:0]   word_t;
  typedef logic [2*REG_BUS-1:0] dword_t;

  localparam word_t ZERO_WORD            = '0;
  localparam logic  RST_ENABLE           = 1'b1;
  localparam logic  DIV_RESULT_READY     = 1'b1;
  localparam logic  DIV_RESULT_NOT_READY = 1'b0;
  localparam logic  DIV_START            = 1'b1;
  localparam logic  DIV_STOP             = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  // Magnitude of a two's-complement word when treated as signed.
  function automatic word_t abs_word(word_t value, logic is_signed);
    return (is_signed && value[REG_BUS-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration over the {remainder, quotient} register.
module div_step
  import div_pkg::*;
(
  input  dword_t work,
  input  word_t  divisor,
  output dword_t work_next
);

  logic [REG_BUS:0] trial;

  // The shifted remainder is 33 bits wide so large unsigned divisors still compare correctly.
  always_comb begin
    trial = work[2*REG_BUS-1:REG_BUS-1] - {1'b0, divisor};
    if (trial[REG_BUS]) begin
      work_next = {work[2*REG_BUS-2:0], 1'b0};
    end else begin
      work_next = {trial[REG_BUS-1:0], work[REG_BUS-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider (DIV/DIVU) with a four-state handshake FSM.
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o, set in DIV_END after a zero divisor.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
`ifdef DIV_ZERO_FLAG_EN
  output logic        div_zero_o,
`endif
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_t         state;
  logic [CNT_W-1:0]   cnt;
  dword_t             work;
  dword_t             work_next;
  word_t              divisor;
  logic               signed_op;
  logic               dividend_neg;
  logic               divisor_neg;
  word_t              quo_fix;
  word_t              rem_fix;

  div_step u_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_next)
  );

  // Quotient sign follows the operand signs; remainder follows the dividend.
  always_comb begin
    quo_fix = work[REG_BUS-1:0];
    rem_fix = work[2*REG_BUS-1:REG_BUS];
    if (signed_op && (dividend_neg ^ divisor_neg)) quo_fix = -work[REG_BUS-1:0];
    if (signed_op && dividend_neg)                 rem_fix = -work[2*REG_BUS-1:REG_BUS];
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      work         <= '0;
      divisor      <= ZERO_WORD;
      signed_op    <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      result_o     <= '0;
      ready_o      <= DIV_RESULT_NOT_READY;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_o   <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == ZERO_WORD) begin
              state <= DIV_BY_ZERO;
            end else begin
              state        <= DIV_ON;
              cnt          <= '0;
              work         <= {ZERO_WORD, abs_word(opdata1_i, signed_div_i)};
              divisor      <= abs_word(opdata2_i, signed_div_i);
              signed_op    <= signed_div_i;
              dividend_neg <= opdata1_i[REG_BUS-1];
              divisor_neg  <= opdata2_i[REG_BUS-1];
            end
          end
        end
        DIV_BY_ZERO: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state      <= DIV_END;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_READY;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b1;
`endif
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else if (cnt == CNT_W'(REG_BUS)) begin
            state    <= DIV_END;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= DIV_RESULT_READY;
          end else begin
            work <= work_next;
            cnt  <= cnt + 1'b1;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state      <= DIV_FREE;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_NOT_READY;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule
